// File: rtl/mode_switch_scanner.sv
// Mode slide-switch front end: 2-flop synchroniser, debounce FSM and one-hot validation.
// Optional build macro MODE_SCAN_HOLD_LAST_EN keeps the last valid request when 000 or a multi-bit pattern is accepted.
module mode_switch_scanner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned CNT_W           = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw_raw,
    output logic [2:0] x_out,
    output logic       mode_valid,
    output logic       mode_changed,
    output logic       err
);

    typedef enum logic {
        SETTLING = 1'b0,
        STABLE   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       cand;
    logic [CNT_W-1:0] cnt;

    logic             cand_onehot;
    logic             cand_multi;
    logic [2:0]       dec_x;
    logic             dec_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

    always_comb begin
        cand_onehot = (cand == 3'b001) || (cand == 3'b010) || (cand == 3'b100);
        cand_multi  = (cand != 3'b000) && !cand_onehot;
`ifdef MODE_SCAN_HOLD_LAST_EN
        dec_x     = x_out;
        dec_valid = mode_valid;
        if (cand_onehot) begin
            dec_x     = cand;
            dec_valid = 1'b1;
        end
`else
        dec_x     = cand_onehot ? cand : 3'b000;
        dec_valid = cand_onehot;
`endif
    end

    // A new s2 value always wins over expiry, so a late change can never
    // let the stale candidate through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SETTLING;
            cand         <= '0;
            cnt          <= '0;
            x_out        <= '0;
            mode_valid   <= 1'b0;
            mode_changed <= 1'b0;
            err          <= 1'b0;
        end else begin
            mode_changed <= 1'b0;
            case (state)
                SETTLING: begin
                    if (s2 != cand) begin
                        cand <= s2;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= STABLE;
                        x_out        <= dec_x;
                        mode_valid   <= dec_valid;
                        err          <= cand_multi;
                        mode_changed <= (dec_x != x_out);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (s2 != cand) begin
                        state <= SETTLING;
                        cand  <= s2;
                        cnt   <= '0;
                    end
                end
                default: state <= SETTLING;
            endcase
        end
    end

endmodule

// File: tb/tb_mode_switch_scanner.sv
// Scoreboard bench for mode_switch_scanner with DEBOUNCE_CYCLES=4, CNT_W=3.
// Every expected acceptance is queued with its edge number and checked each cycle.
module tb_mode_switch_scanner;

    localparam int D   = 4;
    localparam int LAT = D + 3;

    logic       clk;
    logic       rst;
    logic [2:0] sw_raw;
    logic [2:0] x_out;
    logic       mode_valid;
    logic       mode_changed;
    logic       err;

    typedef struct {
        int         cyc;
        logic [2:0] x;
        logic       v;
        logic       e;
        logic       p;
    } exp_t;

    exp_t sb[$];

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [2:0] cur_x = 3'b000;
    logic       cur_v = 1'b0;
    logic       cur_e = 1'b0;

    mode_switch_scanner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .x_out(x_out),
        .mode_valid(mode_valid),
        .mode_changed(mode_changed),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue an acceptance expected LAT edges after a drive made just after edge cyc.
    task automatic expect_accept(input logic [2:0] x, input logic v, input logic e, input logic p);
        exp_t t;
        t.cyc = cyc + LAT;
        t.x   = x;
        t.v   = v;
        t.e   = e;
        t.p   = p;
        sb.push_back(t);
    endtask

    task automatic advance(input int n);
        exp_t t;
        logic exp_p;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            exp_p = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                t     = sb.pop_front();
                cur_x = t.x;
                cur_v = t.v;
                cur_e = t.e;
                exp_p = t.p;
            end
            checks++;
            if ({x_out, mode_valid, err, mode_changed} !== {cur_x, cur_v, cur_e, exp_p}) begin
                failures++;
                $display("FAIL outputs@edge%0d: x_out=%b valid=%b err=%b changed=%b, expected x_out=%b valid=%b err=%b changed=%b",
                         cyc, x_out, mode_valid, err, mode_changed, cur_x, cur_v, cur_e, exp_p);
            end
        end
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        sw_raw = 3'b000;
        #1;
        checks++;
        if ({x_out, mode_valid, err, mode_changed} !== 6'b0) begin
            failures++;
            $display("FAIL reset_state: got %b, expected 000000", {x_out, mode_valid, err, mode_changed});
        end
        advance(3);
        rst = 1'b0;
        advance(10);
    endtask

    task automatic test_basic_latency;
        sw_raw = 3'b010;
        expect_accept(3'b010, 1'b1, 1'b0, 1'b1);
        advance(10);
    endtask

    task automatic test_bounce;
        for (int k = 0; k < 5; k++) begin
            sw_raw = 3'b001;
            advance(1);
            sw_raw = 3'b000;
            advance(2);
        end
        sw_raw = 3'b001;
        expect_accept(3'b001, 1'b1, 1'b0, 1'b1);
        advance(10);
    endtask

    task automatic test_invalid;
        sw_raw = 3'b100;
        expect_accept(3'b100, 1'b1, 1'b0, 1'b1);
        advance(9);
        sw_raw = 3'b110;
`ifdef MODE_SCAN_HOLD_LAST_EN
        expect_accept(3'b100, 1'b1, 1'b1, 1'b0);
`else
        expect_accept(3'b000, 1'b0, 1'b1, 1'b1);
`endif
        advance(9);
        sw_raw = 3'b000;
`ifdef MODE_SCAN_HOLD_LAST_EN
        expect_accept(3'b100, 1'b1, 1'b0, 1'b0);
`else
        expect_accept(3'b000, 1'b0, 1'b0, 1'b0);
`endif
        advance(9);
    endtask

    task automatic test_glitch_back;
        sw_raw = 3'b010;
        expect_accept(3'b010, 1'b1, 1'b0, 1'b1);
        advance(9);
        sw_raw = 3'b001;
        advance(3);
        sw_raw = 3'b010;
        advance(12);
    endtask

    task automatic test_async_reset;
        sw_raw = 3'b001;
        advance(3);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        cur_x = 3'b000;
        cur_v = 1'b0;
        cur_e = 1'b0;
        checks++;
        if ({x_out, mode_valid, err, mode_changed} !== 6'b0) begin
            failures++;
            $display("FAIL async_reset: got %b, expected 000000", {x_out, mode_valid, err, mode_changed});
        end
        advance(2);
        rst = 1'b0;
        expect_accept(3'b001, 1'b1, 1'b0, 1'b1);
        advance(10);
    endtask

    task automatic test_collision;
        sw_raw = 3'b010;
        advance(4);
        sw_raw = 3'b100;
        expect_accept(3'b100, 1'b1, 1'b0, 1'b1);
        advance(12);
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_bounce();
        test_invalid();
        test_glitch_back();
        test_async_reset();
        test_collision();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
